cla4_reg: RTL and testbench
===========================

Name: cla4_reg

Overview:
- 4-bit carry-lookahead adder with registered outputs.
- Computes a + b + ci through a two-level generate/propagate lookahead network. It does not ripple the carry.
- Sum, carry-out and group propagate/generate are captured on the rising clock edge.
- Serves as the arithmetic leaf cell for wider adders. Wider adders either cascade `co` into the next `ci`, or use `pg`/`gg` in a second-level lookahead unit.

Parameters:
- None. Width is fixed at 4 bits.

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- rst  input  1  synchronous, active-high reset
- a    input  4  operand A, unsigned
- b    input  4  operand B, unsigned
- ci   input  1  carry-in
- s    output 4  registered sum bits [3:0]
- co   output 1  registered carry-out (bit 4 of the result)
- pg   output 1  registered group propagate = p3&p2&p1&p0
- gg   output 1  registered group generate = g3 | p3&g2 | p3&p2&g1 | p3&p2&p1&g0

Behaviour:
- Interface: one clock (`clk`); reset `rst` is synchronous and active-high. No asynchronous reset path exists.
- Per-bit signals, for i = 0..3:
  - gi = ai & bi
  - pi = ai ^ bi
- Lookahead carries, with c0 = ci. Each carry is a flat sum-of-products, with no chained dependence on earlier computed carries:
  - c1 = g0 | p0&c0
  - c2 = g1 | p1&g0 | p1&p0&c0
  - c3 = g2 | p2&g1 | p2&p1&g0 | p2&p1&p0&c0
  - c4 = gg | pg&c0
- Sum bits: si = pi ^ ci (using the lookahead carry ci for bit i).
- Structure:
  - Full-adder-style cells generate p/g/sum.
  - A separate lookahead carry unit forms c1..c4, pg and gg.
  - An output register stage follows.
- Result identity: {co, s} equals the 5-bit value a + b + ci for every input combination. All 512 combinations must match.
- Latency:
  - Outputs reflect inputs sampled at a rising edge, visible after that edge. Latency is 1 cycle.
  - Throughput is one addition per cycle.
  - Inputs changing between edges do not affect the outputs until the next edge.
- Reset:
  - When `rst` = 1 at a rising edge: s = 4'b0000, co = 0, pg = 0, gg = 0.
  - Reset overrides the sampled inputs.
  - The first valid result appears on the edge after `rst` deasserts.
- Reset mid-operation: any in-flight result is discarded, and the outputs read zero on the following cycle.
- Overflow: unsigned overflow is reported only through `co`. There is no signed-overflow flag and no saturation; the sum wraps modulo 16.
- Boundary cases:
  - a = b = 4'hF, ci = 1 gives s = 4'hF, co = 1.
  - a = b = 0, ci = 1 gives s = 1, co = 0.
- Outputs must never be X after the first reset edge, provided the inputs are known.

Test Plan:
- Reset: hold rst = 1 for 2 cycles with a = 5, b = 9, ci = 1 -> s = 0000, co = 0, pg = 0, gg = 0. After release, next edge -> s = 1111, co = 0.
- Basic sums with ci = 0, one per cycle, checked after each edge:
  - 0+0 -> {co,s} = 0_0000
  - 1+1 -> 0_0010
  - 2+3 -> 0_0101
  - 7+7 -> 0_1110
- Carry-out: a = b = 1111, ci = 0 -> s = 1110, co = 1, gg = 1, pg = 0. Then ci = 1 -> s = 1111, co = 1.
- Full propagate chain: a = 1010, b = 0101, ci = 1 -> s = 0000, co = 1, pg = 1, gg = 0. With ci = 0 -> s = 1111, co = 0.
- Mid-operation reset: apply a = b = 1111, ci = 1, and assert rst on the same edge -> outputs all zero. Deassert rst -> next edge gives s = 1111, co = 1.
- Exhaustive: sweep all 512 (a, b, ci) combinations one per cycle; compare {co, s} against a + b + ci, delayed one cycle.

Source files
------------

// File: rtl/cla4_reg.sv
// ============================================================================
//  Module   : cla4_reg
//  Purpose  : 4-bit carry-lookahead adder with registered sum, carry-out and
//             group propagate/generate outputs.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

// Per-bit cell: forms propagate/generate and the sum from the lookahead carry.
module cla4_pfa (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic p,
  output logic g,
  output logic s
);
  assign p = a ^ b;
  assign g = a & b;
  assign s = p ^ c;
endmodule

// Lookahead carry unit: each carry is a flat sum-of-products of p/g and c0.
module cla4_lcu (
  input  logic [3:0] p,
  input  logic [3:0] g,
  input  logic       c0,
  output logic [3:0] c,
  output logic       c4,
  output logic       pg,
  output logic       gg
);
  assign c[0] = c0;
  assign c[1] = g[0] | (p[0] & c0);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & c0);

  assign pg = p[3] & p[2] & p[1] & p[0];
  assign gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
            | (p[3] & p[2] & p[1] & g[0]);
  assign c4 = gg | (pg & c0);
endmodule

module cla4_reg (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co,
  output logic       pg,
  output logic       gg
);
  logic [3:0] w_p;
  logic [3:0] w_g;
  logic [3:0] w_c;
  logic [3:0] w_s;
  logic       w_c4;
  logic       w_pg;
  logic       w_gg;

  logic [3:0] r_s;
  logic       r_co;
  logic       r_pg;
  logic       r_gg;

  for (genvar i = 0; i < 4; i++) begin : g_bit
    cla4_pfa u_pfa (
      .a (a[i]),
      .b (b[i]),
      .c (w_c[i]),
      .p (w_p[i]),
      .g (w_g[i]),
      .s (w_s[i])
    );
  end

  cla4_lcu u_lcu (
    .p  (w_p),
    .g  (w_g),
    .c0 (ci),
    .c  (w_c),
    .c4 (w_c4),
    .pg (w_pg),
    .gg (w_gg)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s  <= 4'b0000;
      r_co <= 1'b0;
      r_pg <= 1'b0;
      r_gg <= 1'b0;
    end else begin
      r_s  <= w_s;
      r_co <= w_c4;
      r_pg <= w_pg;
      r_gg <= w_gg;
    end
  end

  assign s  = r_s;
  assign co = r_co;
  assign pg = r_pg;
  assign gg = r_gg;
endmodule

`default_nettype wire

// File: tb/tb_cla4_reg.sv
// ============================================================================
//  Module   : tb_cla4_reg
//  Purpose  : Self-checking bench for cla4_reg (directed table + sweep).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cla4_reg;
  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] a;
  logic [3:0] b;
  logic       ci;
  logic [3:0] s;
  logic       co;
  logic       pg;
  logic       gg;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       ci;
    logic [3:0] s;
    logic       co;
    logic       pg;
    logic       gg;
    string      name;
  } vec_t;

  vec_t vecs[10];

  cla4_reg dut (
    .clk (clk),
    .rst (rst),
    .a   (a),
    .b   (b),
    .ci  (ci),
    .s   (s),
    .co  (co),
    .pg  (pg),
    .gg  (gg)
  );

  always #5 clk = ~clk;

  // Compares the packed {co, s, pg, gg} observation against the expectation.
  task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual {co,s,pg,gg}=%b required=%b", name, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic [3:0] ta, input logic [3:0] tb_v, input logic tci);
    @(negedge clk);
    rst = r;
    a   = ta;
    b   = tb_v;
    ci  = tci;
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0] = '{4'h0, 4'h0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, "0+0"};
    vecs[1] = '{4'h1, 4'h1, 1'b0, 4'b0010, 1'b0, 1'b0, 1'b0, "1+1"};
    vecs[2] = '{4'h2, 4'h3, 1'b0, 4'b0101, 1'b0, 1'b0, 1'b0, "2+3"};
    vecs[3] = '{4'h7, 4'h7, 1'b0, 4'b1110, 1'b0, 1'b0, 1'b0, "7+7"};
    vecs[4] = '{4'hF, 4'hF, 1'b0, 4'b1110, 1'b1, 1'b0, 1'b1, "F+F+0"};
    vecs[5] = '{4'hF, 4'hF, 1'b1, 4'b1111, 1'b1, 1'b0, 1'b1, "F+F+1"};
    vecs[6] = '{4'hA, 4'h5, 1'b1, 4'b0000, 1'b1, 1'b1, 1'b0, "A+5+1"};
    vecs[7] = '{4'hA, 4'h5, 1'b0, 4'b1111, 1'b0, 1'b1, 1'b0, "A+5+0"};
    vecs[8] = '{4'h8, 4'h8, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b1, "8+8"};
    vecs[9] = '{4'h0, 4'h0, 1'b1, 4'b0001, 1'b0, 1'b0, 1'b0, "0+0+1"};

    rst = 1'b1;
    a   = 4'h0;
    b   = 4'h0;
    ci  = 1'b0;

    // Reset held two cycles with live operands, then first result.
    step(1'b1, 4'h5, 4'h9, 1'b1);
    check("reset_c1", {co, s, pg, gg}, 7'b0_0000_00);
    step(1'b1, 4'h5, 4'h9, 1'b1);
    check("reset_c2", {co, s, pg, gg}, 7'b0_0000_00);
    step(1'b0, 4'h5, 4'h9, 1'b1);
    check("post_reset", {co, s, pg, gg}, 7'b0_1111_00);

    foreach (vecs[i]) begin
      step(1'b0, vecs[i].a, vecs[i].b, vecs[i].ci);
      check(vecs[i].name, {co, s, pg, gg},
            {vecs[i].co, vecs[i].s, vecs[i].pg, vecs[i].gg});
    end

    // Mid-operation reset discards the result sampled on the same edge.
    step(1'b1, 4'hF, 4'hF, 1'b1);
    check("mid_reset", {co, s, pg, gg}, 7'b0_0000_00);
    step(1'b0, 4'hF, 4'hF, 1'b1);
    check("after_mid_reset", {co, s, pg, gg}, 7'b1_1111_01);

    // Inputs changed between edges must not reach the outputs.
    step(1'b0, 4'h3, 4'h4, 1'b0);
    check("hold_before", {co, s, pg, gg}, 7'b0_0111_00);
    #2;
    a  = 4'hF;
    b  = 4'hF;
    ci = 1'b1;
    #1;
    check("hold_between_edges", {co, s, pg, gg}, 7'b0_0111_00);

    // Exhaustive sweep against arithmetic model.
    for (int i = 0; i < 512; i++) begin
      logic [3:0] ea;
      logic [3:0] eb;
      logic       ec;
      logic [4:0] sum;
      logic [4:0] sum0;
      logic       epg;
      ea   = i[8:5];
      eb   = i[4:1];
      ec   = i[0];
      sum  = {1'b0, ea} + {1'b0, eb} + {4'b0, ec};
      sum0 = {1'b0, ea} + {1'b0, eb};
      epg  = ((ea ^ eb) == 4'hF);
      step(1'b0, ea, eb, ec);
      check($sformatf("sweep a=%h b=%h ci=%b", ea, eb, ec), {co, s, pg, gg},
            {sum, epg, sum0[4]});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

`default_nettype wire
